// File: rtl/riscv_defines.sv
// Shared fetch-stage definitions: word width, canonical NOP encoding and fetch FSM states.
package riscv_defines;
  localparam int WORD_WIDTH = 32;
  localparam logic [WORD_WIDTH-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_GNT    = 2'd1,
    WAIT_RVALID = 2'd2
  } fetch_state_t;

  function automatic logic [WORD_WIDTH-1:0] align_word(input logic [WORD_WIDTH-1:0] addr);
    return {addr[WORD_WIDTH-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// Two-entry {instruction, pc} buffer between the memory response and the IF/ID register.
module fetch_fifo
  import riscv_defines::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [WORD_WIDTH-1:0] push_instr,
  input  logic [WORD_WIDTH-1:0] push_pc,
  output logic [WORD_WIDTH-1:0] head_instr,
  output logic [WORD_WIDTH-1:0] head_pc,
  output logic                  full,
  output logic                  empty
);
  logic [WORD_WIDTH-1:0] instr_q [2];
  logic [WORD_WIDTH-1:0] pc_q    [2];
  logic                  rd_ptr;
  logic                  wr_ptr;
  logic [1:0]            count;
  logic                  do_push;
  logic                  do_pop;

  // A push into a full buffer is accepted only when the head leaves in the same cycle.
  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd2) || do_pop);
  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);

  assign head_instr = instr_q[rd_ptr];
  assign head_pc    = pc_q[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      instr_q[wr_ptr] <= push_instr;
      pc_q[wr_ptr]    <= push_pc;
    end
  end
endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: single-outstanding memory requester with redirect/discard and a 2-entry buffer.
module instr_fetch
  import riscv_defines::*;
#(
  parameter logic [WORD_WIDTH-1:0] BOOT_ADDR = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_ctrl,
  input  logic                  branch_ctrl,
  input  logic [WORD_WIDTH-1:0] branch_target_i,
  output logic                  instr_req_o,
  output logic [WORD_WIDTH-1:0] instr_addr_o,
  input  logic                  instr_gnt_i,
  input  logic                  instr_rvalid_i,
  input  logic [WORD_WIDTH-1:0] instr_rdata_i,
  output logic [WORD_WIDTH-1:0] instruction_o,
  output logic [WORD_WIDTH-1:0] program_count_o,
  output logic                  no_op_flag_o
);
  localparam logic [WORD_WIDTH-1:0] BOOT_ALIGNED = {BOOT_ADDR[WORD_WIDTH-1:2], 2'b00};

  fetch_state_t          state;
  logic [WORD_WIDTH-1:0] fetch_addr;
  logic [WORD_WIDTH-1:0] req_addr;
  logic                  discard;
  logic [WORD_WIDTH-1:0] target;
  logic [WORD_WIDTH-1:0] next_addr;
  logic                  push;
  logic                  pop;
  logic                  full;
  logic                  empty;
  logic [1:0]            occ;
  logic [1:0]            occ_next;
  logic                  room;
  logic [WORD_WIDTH-1:0] head_instr;
  logic [WORD_WIDTH-1:0] head_pc;

  assign target    = align_word(branch_target_i);
  assign next_addr = branch_ctrl ? target : fetch_addr;
  assign push      = (state == WAIT_RVALID) && instr_rvalid_i && !discard && !branch_ctrl;
  assign pop       = !empty && !stall_ctrl && !branch_ctrl;
  assign occ       = full ? 2'd2 : (empty ? 2'd0 : 2'd1);

  always_comb begin
    occ_next = occ;
    if (branch_ctrl) occ_next = 2'd0;
    else             occ_next = occ + {1'b0, push} - {1'b0, pop};
  end

  assign room = (occ_next < 2'd2);

  fetch_fifo u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .pop        (pop),
    .flush      (branch_ctrl),
    .push_instr (instr_rdata_i),
    .push_pc    (req_addr),
    .head_instr (head_instr),
    .head_pc    (head_pc),
    .full       (full),
    .empty      (empty)
  );

  // req_addr is the address on the bus; fetch_addr is the next address to request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      fetch_addr  <= BOOT_ALIGNED;
      req_addr    <= BOOT_ALIGNED;
      discard     <= 1'b0;
      instr_req_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          fetch_addr <= next_addr;
          if (room) begin
            state       <= WAIT_GNT;
            instr_req_o <= 1'b1;
            req_addr    <= next_addr;
          end
        end
        WAIT_GNT: begin
          if (instr_gnt_i) begin
            state       <= WAIT_RVALID;
            instr_req_o <= 1'b0;
            discard     <= discard || branch_ctrl;
            if (branch_ctrl)   fetch_addr <= target;
            else if (!discard) fetch_addr <= req_addr + 32'd4;
          end else if (branch_ctrl) begin
            discard    <= 1'b1;
            fetch_addr <= target;
          end
        end
        WAIT_RVALID: begin
          if (instr_rvalid_i) begin
            discard    <= 1'b0;
            fetch_addr <= next_addr;
            if (room) begin
              state       <= WAIT_GNT;
              instr_req_o <= 1'b1;
              req_addr    <= next_addr;
            end else begin
              state <= IDLE;
            end
          end else if (branch_ctrl) begin
            discard    <= 1'b1;
            fetch_addr <= target;
          end
        end
        default: begin
          state       <= IDLE;
          instr_req_o <= 1'b0;
        end
      endcase
    end
  end

  assign instr_addr_o    = req_addr;
  assign instruction_o   = empty ? NOP_INSTR : head_instr;
  assign program_count_o = empty ? '0 : head_pc;
  assign no_op_flag_o    = empty;
endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: a latency-configurable memory model plus per-scenario tasks.
module tb_instr_fetch;
  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_ctrl;
  logic        branch_ctrl;
  logic [31:0] branch_target_i;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i;
  logic        instr_rvalid_i;
  logic [31:0] instr_rdata_i;
  logic [31:0] instruction_o;
  logic [31:0] program_count_o;
  logic        no_op_flag_o;

  int          n_cmp = 0;
  int          n_fail = 0;
  exp_t        sb [$];
  logic [31:0] grant_log [$];
  bit          gnt_en;
  int          lat;
  int          rv_cnt;
  logic [31:0] pend_addr;

  instr_fetch #(.BOOT_ADDR(32'h0000_0080)) dut (
    .clk             (clk),
    .rst             (rst),
    .stall_ctrl      (stall_ctrl),
    .branch_ctrl     (branch_ctrl),
    .branch_target_i (branch_target_i),
    .instr_req_o     (instr_req_o),
    .instr_addr_o    (instr_addr_o),
    .instr_gnt_i     (instr_gnt_i),
    .instr_rvalid_i  (instr_rvalid_i),
    .instr_rdata_i   (instr_rdata_i),
    .instruction_o   (instruction_o),
    .program_count_o (program_count_o),
    .no_op_flag_o    (no_op_flag_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  function automatic exp_t mk(input logic [31:0] pc);
    exp_t e;
    e.ins = mem_word(pc);
    e.pc  = pc;
    return e;
  endfunction

  // One clock: score this cycle's consumption, cross the edge, then drive the memory response.
  task automatic tick();
    exp_t e;
    if (!rst && !no_op_flag_o && !stall_ctrl && !branch_ctrl) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output: got pc=%h ins=%h, required none", program_count_o, instruction_o);
      end else begin
        e = sb.pop_front();
        if (program_count_o !== e.pc || instruction_o !== e.ins) begin
          n_fail++;
          $display("FAIL output_order: got pc=%h ins=%h, required pc=%h ins=%h",
                   program_count_o, instruction_o, e.pc, e.ins);
        end
      end
    end
    @(posedge clk);
    #1;
    instr_rvalid_i = 1'b0;
    if (rv_cnt > 0) begin
      rv_cnt--;
      if (rv_cnt == 0) begin
        instr_rvalid_i = 1'b1;
        instr_rdata_i  = mem_word(pend_addr);
      end
    end
    instr_gnt_i = gnt_en && !rst && instr_req_o && (rv_cnt == 0);
    if (instr_gnt_i) begin
      grant_log.push_back(instr_addr_o);
      pend_addr = instr_addr_o;
      rv_cnt    = lat;
    end
  endtask

  task automatic reset_dut();
    @(posedge clk);
    #1;
    rst = 1'b1;
    stall_ctrl = 1'b0;
    branch_ctrl = 1'b0;
    branch_target_i = '0;
    instr_gnt_i = 1'b0;
    instr_rvalid_i = 1'b0;
    instr_rdata_i = '0;
    gnt_en = 1'b1;
    lat = 1;
    rv_cnt = 0;
    sb.delete();
    grant_log.delete();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic drain(input string name, input int max_cycles);
    for (int i = 0; i < max_cycles && sb.size() > 0; i++) tick();
    if (sb.size() > 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_timeout: got %0d items still expected, required 0", name, sb.size());
    end
    stall_ctrl = 1'b1;
  endtask

  task automatic test_reset();
    reset_dut();
    rst = 1'b1;
    tick();
    n_cmp++; if (instr_req_o !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b required 0", instr_req_o); end
    n_cmp++; if (no_op_flag_o !== 1'b1) begin n_fail++; $display("FAIL rst_noop: got %b required 1", no_op_flag_o); end
    n_cmp++; if (instruction_o !== 32'h0000_0013) begin n_fail++; $display("FAIL rst_instr: got %h required 00000013", instruction_o); end
    n_cmp++; if (program_count_o !== 32'h0) begin n_fail++; $display("FAIL rst_pc: got %h required 0", program_count_o); end
    rst = 1'b0;
  endtask

  task automatic test_stream();
    int n;
    reset_dut();
    sb.push_back(mk(32'h80)); sb.push_back(mk(32'h84)); sb.push_back(mk(32'h88));
    n = 0;
    while (!instr_gnt_i && n < 10) begin tick(); n++; end
    n_cmp++; if (instr_addr_o !== 32'h80 || !instr_gnt_i) begin n_fail++; $display("FAIL stream_first_addr: got %h gnt=%b required 00000080", instr_addr_o, instr_gnt_i); end
    tick();
    n_cmp++; if (no_op_flag_o !== 1'b1) begin n_fail++; $display("FAIL stream_lat_n1: got noop=%b required 1", no_op_flag_o); end
    tick();
    n_cmp++; if (no_op_flag_o !== 1'b0 || program_count_o !== 32'h80) begin n_fail++; $display("FAIL stream_lat_n2: got noop=%b pc=%h required 0/00000080", no_op_flag_o, program_count_o); end
    drain("stream", 30);
    n_cmp++;
    if (grant_log.size() < 3 || grant_log[0] !== 32'h80 || grant_log[1] !== 32'h84 || grant_log[2] !== 32'h88) begin
      n_fail++; $display("FAIL stream_addrs: got %0d grants, required 80,84,88 first", grant_log.size());
    end
  endtask

  task automatic test_stall();
    reset_dut();
    stall_ctrl = 1'b1;
    sb.push_back(mk(32'h80)); sb.push_back(mk(32'h84)); sb.push_back(mk(32'h88));
    for (int i = 0; i < 5; i++) tick();
    n_cmp++; if (instr_req_o !== 1'b0) begin n_fail++; $display("FAIL stall_req_drop: got %b required 0", instr_req_o); end
    n_cmp++; if (program_count_o !== 32'h80 || instruction_o !== mem_word(32'h80)) begin n_fail++; $display("FAIL stall_hold: got pc=%h required 00000080", program_count_o); end
    tick();
    n_cmp++; if (program_count_o !== 32'h80 || instr_req_o !== 1'b0) begin n_fail++; $display("FAIL stall_hold2: got pc=%h req=%b required 00000080/0", program_count_o, instr_req_o); end
    stall_ctrl = 1'b0;
    drain("stall", 30);
  endtask

  task automatic test_flush();
    reset_dut();
    stall_ctrl = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    branch_ctrl = 1'b1;
    branch_target_i = 32'h0000_0301;
    tick();
    branch_ctrl = 1'b0;
    n_cmp++; if (no_op_flag_o !== 1'b1 || program_count_o !== 32'h0) begin n_fail++; $display("FAIL flush_empty: got noop=%b pc=%h required 1/0", no_op_flag_o, program_count_o); end
    n_cmp++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h300) begin n_fail++; $display("FAIL flush_next_addr: got req=%b addr=%h required 1/00000300", instr_req_o, instr_addr_o); end
    stall_ctrl = 1'b0;
    sb.push_back(mk(32'h300));
    drain("flush", 20);
  endtask

  task automatic test_branch(input int mem_lat);
    int n;
    int idx;
    reset_dut();
    lat = mem_lat;
    sb.push_back(mk(32'h80)); sb.push_back(mk(32'h84)); sb.push_back(mk(32'h88)); sb.push_back(mk(32'h8C));
    n = 0;
    while (!(instr_gnt_i && instr_addr_o == 32'h90) && n < 60) begin tick(); n++; end
    tick();
    branch_ctrl = 1'b1;
    branch_target_i = 32'h0000_1002;
    tick();
    branch_ctrl = 1'b0;
    sb.push_back(mk(32'h1000)); sb.push_back(mk(32'h1004));
    drain("branch", 40);
    idx = -1;
    for (int i = 0; i < grant_log.size(); i++) if (grant_log[i] == 32'h90 && idx < 0) idx = i;
    n_cmp++;
    if (idx < 0 || idx + 1 >= grant_log.size() || grant_log[idx+1] !== 32'h1000) begin
      n_fail++; $display("FAIL branch_target_addr_lat%0d: got idx=%0d, required request 00001000 after 00000090", mem_lat, idx);
    end
  endtask

  task automatic test_gnt_hold();
    reset_dut();
    gnt_en = 1'b0;
    branch_ctrl = 1'b1;
    branch_target_i = 32'h0000_0040;
    tick();
    branch_target_i = 32'h0000_0200;
    n_cmp++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h40) begin n_fail++; $display("FAIL hold_c0: got req=%b addr=%h required 1/00000040", instr_req_o, instr_addr_o); end
    tick();
    branch_ctrl = 1'b0;
    n_cmp++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h40) begin n_fail++; $display("FAIL hold_c1: got req=%b addr=%h required 1/00000040", instr_req_o, instr_addr_o); end
    gnt_en = 1'b1;
    tick();
    n_cmp++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h40) begin n_fail++; $display("FAIL hold_c2: got req=%b addr=%h required 1/00000040", instr_req_o, instr_addr_o); end
    sb.push_back(mk(32'h200)); sb.push_back(mk(32'h204));
    drain("hold", 30);
    n_cmp++;
    if (grant_log.size() < 2 || grant_log[0] !== 32'h40 || grant_log[1] !== 32'h200) begin
      n_fail++; $display("FAIL hold_grant_seq: got %0d grants, required 40 then 200", grant_log.size());
    end
  endtask

  task automatic test_wrap();
    reset_dut();
    branch_ctrl = 1'b1;
    branch_target_i = 32'hFFFF_FFFE;
    tick();
    branch_ctrl = 1'b0;
    sb.push_back(mk(32'hFFFF_FFFC)); sb.push_back(mk(32'h0)); sb.push_back(mk(32'h4));
    drain("wrap", 30);
    n_cmp++;
    if (grant_log.size() < 2 || grant_log[0] !== 32'hFFFF_FFFC || grant_log[1] !== 32'h0) begin
      n_fail++; $display("FAIL wrap_addr: got %0d grants, required FFFFFFFC then 00000000", grant_log.size());
    end
  endtask

  task automatic test_reset_mid();
    int n;
    reset_dut();
    lat = 3;
    n = 0;
    while (!instr_gnt_i && n < 10) begin tick(); n++; end
    tick();
    rst = 1'b1;
    tick();
    n_cmp++; if (no_op_flag_o !== 1'b1 || instruction_o !== 32'h0000_0013 || instr_req_o !== 1'b0) begin
      n_fail++; $display("FAIL midrst_outputs: got noop=%b ins=%h req=%b required 1/00000013/0", no_op_flag_o, instruction_o, instr_req_o);
    end
    rst = 1'b0;
    grant_log.delete();
    sb.push_back(mk(32'h80)); sb.push_back(mk(32'h84));
    tick();
    n_cmp++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h80) begin n_fail++; $display("FAIL midrst_boot_req: got req=%b addr=%h required 1/00000080", instr_req_o, instr_addr_o); end
    drain("midrst", 40);
  endtask

  initial begin
    rst = 1'b1;
    stall_ctrl = 1'b0;
    branch_ctrl = 1'b0;
    branch_target_i = '0;
    instr_gnt_i = 1'b0;
    instr_rvalid_i = 1'b0;
    instr_rdata_i = '0;
    gnt_en = 1'b1;
    lat = 1;
    rv_cnt = 0;
    pend_addr = '0;
    test_reset();
    test_stream();
    test_stall();
    test_flush();
    test_branch(1);
    test_branch(2);
    test_gnt_hold();
    test_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter BOOT_ADDR, default 32'h0000_0000: first fetch address after reset; bits [1:0] ignored.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port stall_ctrl, input, 1: downstream IF/ID register holding; no instruction consumed this cycle.
REQ-005 SHALL have port branch_ctrl, input, 1: one-cycle redirect strobe from the hazard/branch unit.
REQ-006 SHALL have port branch_target_i, input, WORD_WIDTH: redirect address, sampled when branch_ctrl=1; bits [1:0] ignored.
REQ-007 SHALL have port instr_req_o, output, 1: memory request valid.
REQ-008 SHALL have port instr_addr_o, output, WORD_WIDTH: word-aligned request address; bits [1:0] always 0.
REQ-009 SHALL have port instr_gnt_i, input, 1: memory accepted the request this cycle.
REQ-010 SHALL have port instr_rvalid_i, input, 1: instr_rdata_i valid this cycle.
REQ-011 SHALL have port instr_rdata_i, input, WORD_WIDTH: fetched instruction word.
REQ-012 SHALL have ports instruction_o, program_count_o (WORD_WIDTH) and no_op_flag_o (1), outputs, feeding the IF/ID register's instruction_i, program_count_i and no_op_flag_i.

Function
REQ-013 SHALL keep at most one outstanding request (granted, rvalid not yet received).
REQ-014 SHALL use FSM states IDLE (nothing pending), WAIT_GNT (instr_req_o=1), WAIT_RVALID (granted, awaiting data).
REQ-015 SHALL enter WAIT_GNT from IDLE, or from WAIT_RVALID in the rvalid cycle, only when buffer occupancy after this cycle's push/pop is below 2; otherwise it SHALL go or stay IDLE.
REQ-016 SHALL hold instr_req_o=1 with instr_addr_o stable until the instr_gnt_i cycle, including across a redirect; gnt moves the FSM WAIT_GNT->WAIT_RVALID.
REQ-017 SHALL advance the fetch address by 4 on each grant; 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-018 SHALL push {instr_rdata_i, request address} into a 2-entry FIFO on instr_rvalid_i in WAIT_RVALID, unless the response is marked discard.
REQ-019 SHALL drive instruction_o/program_count_o from the FIFO head with no_op_flag_o=0 when non-empty; when empty, instruction_o=NOP_INSTR (32'h0000_0013), program_count_o=0, no_op_flag_o=1.
REQ-020 SHALL pop the head on a cycle with FIFO non-empty and stall_ctrl=0; with stall_ctrl=1 the head SHALL stay unchanged.
REQ-021 SHALL, on branch_ctrl=1: flush the FIFO, set the fetch address to {branch_target_i[31:2],2'b00}, and mark the outstanding or still-ungranted request as discard; the next new request SHALL use the target.
REQ-022 SHALL give branch_ctrl priority over stall_ctrl and over a same-cycle push (that response discarded).
REQ-023 SHALL push and pop in the same cycle with occupancy unchanged, never overflowing or underflowing.
REQ-024 SHALL have latency: grant in cycle N, rvalid in N+1 -> instruction on outputs in cycle N+2 (FIFO previously empty).
REQ-025 SHALL ignore instr_rvalid_i outside WAIT_RVALID.

Reset
REQ-026 SHALL, while rst=1, set FSM=IDLE, fetch address=BOOT_ADDR, FIFO empty, discard flag=0, instr_req_o=0, no_op_flag_o=1, instruction_o=NOP_INSTR, program_count_o=0.
REQ-027 SHALL abandon an in-flight request on reset mid-operation, with no discard state carried over; the first request SHALL issue the cycle after rst deasserts.

Structure
REQ-028 SHALL take WORD_WIDTH, NOP_INSTR and the fetch-state enum typedef from package riscv_defines.
REQ-029 SHALL implement the 2-entry {instruction, pc} buffer as sub-module fetch_fifo (push, pop, flush, full, empty).

Verification
REQ-030 Reset release, BOOT_ADDR=0x80, gnt always 1, rvalid one cycle later -> addresses 0x80,0x84,0x88 issued; output 0x80 with no_op_flag_o=0 two cycles after first grant.
REQ-031 stall_ctrl=1 for 5 cycles with data flowing -> FIFO fills to 2, instr_req_o drops, outputs hold the pc=0x80 instruction; release -> 0x84, 0x88 in order, no loss or duplicate.
REQ-032 branch_ctrl=1 with target 0x1002 while WAIT_RVALID for 0x90 -> 0x90 data discarded, FIFO flushed, next request addr 0x1000, next valid output pc=0x1000.
REQ-033 gnt withheld 3 cycles at addr 0x40 plus redirect to 0x200 in cycle 1 -> addr 0x40 held until gnt, its data discarded, then request 0x200.
REQ-034 Fetch address 0xFFFF_FFFC granted -> next request addr 0x0000_0000.
REQ-035 rst asserted while WAIT_RVALID -> next cycle outputs NOP_INSTR/no_op_flag_o=1, request BOOT_ADDR after release; late rvalid ignored.
